// File: rtl/top_level_pkg.sv
// Shared definitions for the 8-bit accumulator processor: widths, opcodes, states.
package top_level_pkg;

  localparam int PKG_DATA_W  = 8;
  localparam int PKG_ADDR_W  = 8;
  localparam int PKG_INSTR_W = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LDA  = 4'h2,
    OP_STA  = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_XOR  = 4'h8,
    OP_JMP  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JC   = 4'hB,
    OP_ADDI = 4'hC,
    OP_NOT  = 4'hD,
    OP_SHL  = 4'hE,
    OP_HLT  = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/top_level_alu.sv
// Combinational ALU: computes the new accumulator value, carry/borrow and zero flag.
import top_level_pkg::*;

module top_level_alu #(
  parameter int DATA_W = PKG_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] operand,
  input  opcode_t           op,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              c_out,
  output logic              zero
);

  // Opcode-selected operation; ops that do not touch A pass it through with C held.
  always_comb begin
    result = a;
    c_out  = c_in;
    case (op)
      OP_LDI, OP_LDA: result = operand;
      OP_ADD, OP_ADDI: {c_out, result} = {1'b0, a} + {1'b0, operand};
      // Bit DATA_W of the widened difference is the borrow.
      OP_SUB:         {c_out, result} = {1'b0, a} - {1'b0, operand};
      OP_AND:         result = a & operand;
      OP_OR:          result = a | operand;
      OP_XOR:         result = a ^ operand;
      OP_NOT:         result = ~a;
      OP_SHL:         {c_out, result} = {a, 1'b0};
      default:        result = a;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/top_level.sv
// Two-cycle-per-instruction accumulator processor: FETCH loads IR, EXEC runs it.
import top_level_pkg::*;

module top_level #(
  parameter int DATA_W  = PKG_DATA_W,
  parameter int ADDR_W  = PKG_ADDR_W,
  parameter int INSTR_W = PKG_INSTR_W
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [INSTR_W-1:0] din,
  output logic [DATA_W-1:0]  dout,
  output logic [ADDR_W-1:0]  adrs,
  output logic               rw
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   a;
  logic                z, c;

  opcode_t             op;
  logic [ADDR_W-1:0]   k;
  logic [DATA_W-1:0]   m, operand, alu_res;
  logic                alu_c, alu_z;
  logic                wr_a, wr_c, jump;
  logic [3:0]          ir_unused;

  assign op        = opcode_t'(ir[15:12]);
  assign k         = ir[ADDR_W-1:0];
  assign m         = din[DATA_W-1:0];
  assign ir_unused = ir[11:8];
  assign dout      = a;

  // State register; clr returns to FETCH immediately so rw drops back to read.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= ST_FETCH;
    else     state <= state_nxt;
  end

  // Next state and bus outputs: address is k only while executing, write only for STA.
  always_comb begin
    state_nxt = state;
    adrs      = pc;
    rw        = 1'b1;
    case (state)
      ST_FETCH: state_nxt = ST_EXEC;
      ST_EXEC: begin
        adrs      = k;
        rw        = (op != OP_STA);
        state_nxt = (op == OP_HLT) ? ST_HALT : ST_FETCH;
      end
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  // Instruction decode: operand source, which registers update, branch decision.
  always_comb begin
    operand = (op == OP_LDI || op == OP_ADDI) ? k : m;
    wr_a    = 1'b0;
    wr_c    = 1'b0;
    jump    = 1'b0;
    case (op)
      OP_LDI, OP_LDA, OP_AND, OP_OR, OP_XOR, OP_NOT: wr_a = 1'b1;
      OP_ADD, OP_SUB, OP_ADDI, OP_SHL: begin
        wr_a = 1'b1;
        wr_c = 1'b1;
      end
      OP_JMP:  jump = 1'b1;
      OP_JZ:   jump = z;
      OP_JC:   jump = c;
      default: ;
    endcase
  end

  top_level_alu #(.DATA_W(DATA_W)) u_alu (
    .a       (a),
    .operand (operand),
    .op      (op),
    .c_in    (c),
    .result  (alu_res),
    .c_out   (alu_c),
    .zero    (alu_z)
  );

  // Architectural registers: IR/PC advance in FETCH, A/flags/PC update in EXEC.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc <= '0;
      ir <= '0;
      a  <= '0;
      z  <= 1'b0;
      c  <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          ir <= din;
          pc <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        ST_EXEC: begin
          if (wr_a) begin
            a <= alu_res;
            z <= alu_z;
          end
          if (wr_c) c  <= alu_c;
          if (jump) pc <= k;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_top_level.sv
// Directed self-checking bench for the accumulator processor with a behavioural RAM.
module tb_top_level;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] din;
  logic [7:0]  dout;
  logic [7:0]  adrs;
  logic        rw;

  logic [15:0] mem [256];

  int errors = 0;
  int checks = 0;

  top_level dut (
    .clk  (clk),
    .clr  (clr),
    .din  (din),
    .dout (dout),
    .adrs (adrs),
    .rw   (rw)
  );

  always #5 clk = ~clk;

  // RAM: combinational read, write on the rising edge when rw=0.
  assign din = mem[adrs];
  always @(posedge clk) if (!rw) mem[adrs] = {8'h00, dout};

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold clr for two edges, then release on a falling edge (start of cycle 1).
  task automatic pulse_reset();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clear_mem();
    mem[0] = 16'h1011;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (adrs !== 8'h00) begin errors++; $display("FAIL reset_adrs: got %h want 00", adrs); end
    checks++; if (rw !== 1'b1) begin errors++; $display("FAIL reset_rw: got %b want 1", rw); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
    clr = 1'b0;
    checks++; if (adrs !== 8'h00) begin errors++; $display("FAIL first_fetch_adrs: got %h want 00", adrs); end
    step(2);
    checks++; if (dout !== 8'h11) begin errors++; $display("FAIL first_ldi: got %h want 11", dout); end
  endtask

  task automatic test_load_store();
    int wcnt = 0;
    int wcyc = 0;
    logic [7:0] wadr = 8'h00;
    logic [7:0] wdat = 8'h00;
    clear_mem();
    mem[0] = 16'h102A;
    mem[1] = 16'h3080;
    mem[2] = 16'hF000;
    pulse_reset();
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (rw === 1'b0) begin
        wcnt++; wcyc = cyc; wadr = adrs; wdat = dout;
      end
      step(1);
    end
    checks++; if (wcnt !== 1) begin errors++; $display("FAIL sta_write_count: got %0d want 1", wcnt); end
    checks++; if (wcyc !== 4) begin errors++; $display("FAIL sta_write_cycle: got %0d want 4", wcyc); end
    checks++; if (wadr !== 8'h80) begin errors++; $display("FAIL sta_adrs: got %h want 80", wadr); end
    checks++; if (wdat !== 8'h2A) begin errors++; $display("FAIL sta_dout: got %h want 2a", wdat); end
    checks++; if (mem[8'h80][7:0] !== 8'h2A) begin errors++; $display("FAIL sta_ram: got %h want 2a", mem[8'h80][7:0]); end
    checks++; if (dut.pc !== 8'h03) begin errors++; $display("FAIL halt_pc: got %h want 03", dut.pc); end
    step(4);
    checks++; if (adrs !== 8'h03) begin errors++; $display("FAIL halt_adrs: got %h want 03", adrs); end
    checks++; if (rw !== 1'b1) begin errors++; $display("FAIL halt_rw: got %b want 1", rw); end
  endtask

  task automatic test_arith();
    clear_mem();
    mem[0] = 16'h10F0;
    mem[1] = 16'h4081;
    mem[2] = 16'h5081;
    mem[3] = 16'hF000;
    mem[8'h81] = 16'h0020;
    pulse_reset();
    step(4);
    checks++; if (dout !== 8'h10) begin errors++; $display("FAIL add_a: got %h want 10", dout); end
    checks++; if (dut.c !== 1'b1) begin errors++; $display("FAIL add_c: got %b want 1", dut.c); end
    checks++; if (dut.z !== 1'b0) begin errors++; $display("FAIL add_z: got %b want 0", dut.z); end
    step(2);
    checks++; if (dout !== 8'hF0) begin errors++; $display("FAIL sub_a: got %h want f0", dout); end
    checks++; if (dut.c !== 1'b1) begin errors++; $display("FAIL sub_borrow: got %b want 1", dut.c); end
  endtask

  task automatic test_branch(input logic [7:0] subval, input logic taken);
    logic [7:0] exp_a;
    logic [7:0] exp_fetch;
    exp_a     = 8'h05 - subval;
    exp_fetch = taken ? 8'h10 : 8'h03;
    clear_mem();
    mem[0] = 16'h1005;
    mem[1] = 16'h5082;
    mem[2] = 16'hA010;
    mem[8'h82] = {8'h00, subval};
    mem[8'h10] = 16'hF000;
    mem[3] = 16'hF000;
    pulse_reset();
    step(4);
    checks++; if (dout !== exp_a) begin errors++; $display("FAIL jz_sub_a: got %h want %h", dout, exp_a); end
    checks++; if (dut.z !== taken) begin errors++; $display("FAIL jz_flag: got %b want %b", dut.z, taken); end
    step(2);
    checks++; if (adrs !== exp_fetch) begin errors++; $display("FAIL jz_fetch: got %h want %h", adrs, exp_fetch); end
  endtask

  task automatic test_pc_wrap();
    clear_mem();
    mem[0]     = 16'h90FF;
    mem[8'hFF] = 16'h0000;
    pulse_reset();
    step(2);
    checks++; if (adrs !== 8'hFF) begin errors++; $display("FAIL jmp_fetch: got %h want ff", adrs); end
    step(1);
    checks++; if (dut.pc !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %h want 00", dut.pc); end
    step(1);
    checks++; if (adrs !== 8'h00) begin errors++; $display("FAIL wrap_fetch: got %h want 00", adrs); end
  endtask

  task automatic test_logic_ops();
    logic [7:0] exp_a [7];
    exp_a[0] = 8'h3C; exp_a[1] = 8'h0C; exp_a[2] = 8'hAC; exp_a[3] = 8'h53;
    exp_a[4] = 8'hAC; exp_a[5] = 8'h58; exp_a[6] = 8'h00;
    clear_mem();
    mem[0] = 16'h2090;  // LDA
    mem[1] = 16'h6091;  // AND
    mem[2] = 16'h7092;  // OR
    mem[3] = 16'h8093;  // XOR
    mem[4] = 16'hD000;  // NOT
    mem[5] = 16'hE000;  // SHL
    mem[6] = 16'hC0A8;  // ADDI
    mem[7] = 16'hB040;  // JC
    mem[8'h90] = 16'h0F3C;
    mem[8'h91] = 16'h000F;
    mem[8'h92] = 16'h00A0;
    mem[8'h93] = 16'h00FF;
    mem[8'h40] = 16'hF000;
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      step(2);
      checks++; if (dout !== exp_a[i]) begin errors++; $display("FAIL logic_op%0d: got %h want %h", i, dout, exp_a[i]); end
      if (i == 5) begin
        checks++; if (dut.c !== 1'b1) begin errors++; $display("FAIL shl_c: got %b want 1", dut.c); end
      end
    end
    checks++; if (dut.z !== 1'b1) begin errors++; $display("FAIL addi_z: got %b want 1", dut.z); end
    checks++; if (dut.c !== 1'b1) begin errors++; $display("FAIL addi_c: got %b want 1", dut.c); end
    step(2);
    checks++; if (adrs !== 8'h40) begin errors++; $display("FAIL jc_fetch: got %h want 40", adrs); end
  endtask

  task automatic test_reset_mid_sta();
    clear_mem();
    mem[0] = 16'h102A;
    mem[1] = 16'h3080;
    mem[2] = 16'hF000;
    mem[8'h80] = 16'h0055;
    pulse_reset();
    step(3);
    checks++; if (rw !== 1'b0) begin errors++; $display("FAIL pre_clr_rw: got %b want 0", rw); end
    #1 clr = 1'b1;
    #1;
    checks++; if (rw !== 1'b1) begin errors++; $display("FAIL async_rw: got %b want 1", rw); end
    checks++; if (adrs !== 8'h00) begin errors++; $display("FAIL async_adrs: got %h want 00", adrs); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL async_dout: got %h want 00", dout); end
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    checks++; if (mem[8'h80] !== 16'h0055) begin errors++; $display("FAIL ram_kept: got %h want 0055", mem[8'h80]); end
    checks++; if (dut.pc !== 8'h00) begin errors++; $display("FAIL restart_pc: got %h want 00", dut.pc); end
    step(2);
    checks++; if (adrs !== 8'h01) begin errors++; $display("FAIL restart_seq: got %h want 01", adrs); end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_arith();
    test_branch(8'h05, 1'b1);
    test_branch(8'h04, 1'b0);
    test_pc_wrap();
    test_logic_ops();
    test_reset_mid_sta();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
